// File: rtl/ula_pkg.sv
// Shared opcodes, FSM encoding and helpers for the ULA arbiter slice.
package ula_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;

  localparam logic [4:0] OP_ADD = 5'd3;
  localparam logic [4:0] OP_SUB = 5'd4;
  localparam logic [4:0] OP_MUL = 5'd5;
  localparam logic [4:0] OP_DIV = 5'd6;
  localparam logic [4:0] OP_AND = 5'd7;
  localparam logic [4:0] OP_OR  = 5'd8;
  localparam logic [4:0] OP_SHL = 5'd9;
  localparam logic [4:0] OP_SHR = 5'd10;
  localparam logic [4:0] OP_CMP = 5'd11;
  localparam logic [4:0] OP_NOT = 5'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // CMP outcome plus error, as handed back on the response bus
  typedef struct packed {
    logic below;
    logic equal;
    logic above;
    logic error;
  } flags_t;

  function automatic logic is_legal_opcode(input logic [4:0] opc);
    return (opc >= OP_ADD) && (opc <= OP_NOT);
  endfunction

endpackage

// File: rtl/ula.sv
// Combinational ALU; opcode in instr[31:27], results truncated to DWIDTH.
module ula
  import ula_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] instr,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH-1:0] result,
  output logic              below,
  output logic              equal,
  output logic              above,
  output logic              div_zero
);

  logic [4:0] opc;
  assign opc = instr[OPC_MSB:OPC_LSB];

  // Only the opcode field carries meaning; the rest of the word is ignored.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[OPC_LSB-1:0];

  // Single-cycle datapath; unknown opcodes yield zero rather than X.
  always_comb begin
    result   = '0;
    below    = 1'b0;
    equal    = 1'b0;
    above    = 1'b0;
    div_zero = 1'b0;
    case (opc)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_MUL: result = a * b;
      OP_DIV: begin
        if (b == '0) div_zero = 1'b1;
        else         result   = a / b;
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_SHL: result = (b >= DWIDTH'(DWIDTH)) ? '0 : (a << b);
      OP_SHR: result = (b >= DWIDTH'(DWIDTH)) ? '0 : (a >> b);
      OP_CMP: begin
        below = (a < b);
        equal = (a == b);
        above = (a > b);
      end
      OP_NOT: result = ~a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ula_arbiter.sv
// Two-requester round-robin front end for one shared ULA. One op in flight:
// IDLE accepts and registers operands, EXEC captures result/flags, RESP holds.
module ula_arbiter
  import ula_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DWIDTH-1:0] req0_instr,
  input  logic [DWIDTH-1:0] req0_a,
  input  logic [DWIDTH-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DWIDTH-1:0] req1_instr,
  input  logic [DWIDTH-1:0] req1_a,
  input  logic [DWIDTH-1:0] req1_b,
  output logic              rsp_valid,
  output logic              rsp_id,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_result,
  output logic              rsp_below,
  output logic              rsp_equal,
  output logic              rsp_above,
  output logic              rsp_error,
  output logic              busy
);

  state_t            state;
  logic              last_grant;
  logic              owner;
  logic [DWIDTH-1:0] instr_q;
  logic [DWIDTH-1:0] a_q;
  logic [DWIDTH-1:0] b_q;

  // Round-robin pick: on contention favour whoever did not win last time.
  logic any_valid;
  logic grant_id;
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else                          grant_id = req1_valid;
  end

  // Accept only from IDLE; rsp_ready never reaches ready in the same cycle
  // because RESP must first fall back to IDLE.
  logic accept;
  assign accept     = (state == IDLE) && any_valid && !rst;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept &&  grant_id;

  logic [DWIDTH-1:0] alu_result;
  logic              alu_below;
  logic              alu_equal;
  logic              alu_above;
  logic              alu_div_zero;

  ula #(.DWIDTH(DWIDTH)) u_ula (
    .instr    (instr_q),
    .a        (a_q),
    .b        (b_q),
    .result   (alu_result),
    .below    (alu_below),
    .equal    (alu_equal),
    .above    (alu_above),
    .div_zero (alu_div_zero)
  );

  // Sanitise ALU outputs: flags only for CMP, zero result on any error.
  logic [4:0]        opc_q;
  logic              is_cmp;
  flags_t            flags_n;
  logic [DWIDTH-1:0] result_n;
  always_comb begin
    opc_q         = instr_q[OPC_MSB:OPC_LSB];
    is_cmp        = (opc_q == OP_CMP);
    flags_n.error = !is_legal_opcode(opc_q) || alu_div_zero;
    flags_n.below = is_cmp && alu_below;
    flags_n.equal = is_cmp && alu_equal;
    flags_n.above = is_cmp && alu_above;
    result_n      = (flags_n.error || is_cmp) ? '0 : alu_result;
  end

  // Sequencer: grant/latch, capture, then hold the response until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      instr_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_below  <= 1'b0;
      rsp_equal  <= 1'b0;
      rsp_above  <= 1'b0;
      rsp_error  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            instr_q    <= grant_id ? req1_instr : req0_instr;
            a_q        <= grant_id ? req1_a     : req0_a;
            b_q        <= grant_id ? req1_b     : req0_b;
            owner      <= grant_id;
            last_grant <= grant_id;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= result_n;
          rsp_below  <= flags_n.below;
          rsp_equal  <= flags_n.equal;
          rsp_above  <= flags_n.above;
          rsp_error  <= flags_n.error;
          rsp_id     <= owner;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model.
module tb_ula_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_instr, req0_a, req0_b;
  logic [31:0] req1_instr, req1_a, req1_b;
  logic        rsp_valid, rsp_id, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_below, rsp_equal, rsp_above, rsp_error, busy;
  logic [3:0]  rsp_f;

  int checks = 0;
  int errors = 0;

  assign rsp_f = {rsp_below, rsp_equal, rsp_above, rsp_error};

  always #5 clk = ~clk;

  ula_arbiter #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_below(rsp_below), .rsp_equal(rsp_equal),
    .rsp_above(rsp_above), .rsp_error(rsp_error), .busy(busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op);
    logic [26:0] lo;
    lo = 27'($urandom);
    return {op, lo};
  endfunction

  // Reference ALU from the opcode table: f = {below, equal, above, error}
  function automatic void ref_alu(input logic [31:0] instr, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] res,
                                  output logic [3:0] f);
    logic [4:0] op;
    op  = instr[31:27];
    res = 32'd0;
    f   = 4'b0000;
    case (op)
      5'd3:  res = a + b;
      5'd4:  res = a - b;
      5'd5:  res = a * b;
      5'd6:  if (b == 0) f[0] = 1'b1; else res = a / b;
      5'd7:  res = a & b;
      5'd8:  res = a | b;
      5'd9:  res = (b >= 32) ? 32'd0 : a << b[4:0];
      5'd10: res = (b >= 32) ? 32'd0 : a >> b[4:0];
      5'd11: if (a < b) f[3] = 1'b1; else if (a == b) f[2] = 1'b1; else f[1] = 1'b1;
      5'd12: res = ~a;
      default: f[0] = 1'b1;
    endcase
  endfunction

  // Present one op, wait for its grant, then wait for its response.
  // lat = cycles from accept cycle to rsp_valid; ok = 0 if a bound expired.
  task automatic do_op(input bit id, input logic [31:0] instr, input logic [31:0] a,
                       input logic [31:0] b, output int lat, output bit ok);
    ok = 1'b0;
    lat = -1;
    rsp_ready = 1'b1;
    if (id == 1'b0) begin req0_valid = 1'b1; req0_instr = instr; req0_a = a; req0_b = b; end
    else            begin req1_valid = 1'b1; req1_instr = instr; req1_a = a; req1_b = b; end
    #1;
    for (int k = 0; k < 40; k++) begin
      if (id ? req1_ready : req0_ready) begin ok = 1'b1; break; end
      step(); #1;
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!ok) return;
    ok = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (rsp_valid) begin lat = k; ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_instr = mk(5'd3); req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_instr = mk(5'd4); req1_a = 32'd3; req1_b = 32'd4;
    step(); step(); #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
    checks++; if ({rsp_valid, rsp_id, busy} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", {rsp_valid, rsp_id, busy}); end
    checks++; if ({rsp_result, rsp_f} !== 36'd0) begin errors++; $display("FAIL reset_data: got %h/%b want 0", rsp_result, rsp_f); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_add();
    int lat; bit ok;
    do_op(1'b0, mk(5'd3), 32'd5, 32'd7, lat, ok);
    checks++; if (!ok || lat != 2) begin errors++; $display("FAIL add_latency: got ok=%0d lat=%0d want lat=2", ok, lat); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL add_id: got %b want 0", rsp_id); end
    checks++; if (rsp_result !== 32'd12) begin errors++; $display("FAIL add_result: got %0d want 12", rsp_result); end
    checks++; if (rsp_f !== 4'b0000) begin errors++; $display("FAIL add_flags: got %b want 0000", rsp_f); end
    step();
  endtask

  task automatic test_both();
    bit   exp_g;
    int   nrsp;
    bit   q_id[$];
    bit   g;
    rst = 1'b1; step(); rst = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_instr = mk(5'd4); req0_a = 32'd10; req0_b = 32'd3;
    req1_valid = 1'b1; req1_instr = mk(5'd5); req1_a = 32'd6;  req1_b = 32'd7;
    #1;
    exp_g = 1'b0;
    nrsp = 0;
    for (int c = 0; c < 60 && nrsp < 4; c++) begin
      if (req0_ready || req1_ready) begin
        checks++; if ({req1_ready, req0_ready} !== (exp_g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL both_grant: got r1r0=%b want grant %0d", {req1_ready, req0_ready}, exp_g); end
        q_id.push_back(exp_g);
        exp_g = !exp_g;
      end
      if (rsp_valid) begin
        if (q_id.size() == 0) begin
          checks++; errors++; $display("FAIL both_spurious: rsp_valid with no grant outstanding");
        end else begin
          g = q_id.pop_front();
          checks++; if (rsp_id !== g) begin errors++; $display("FAIL both_id: got %b want %b", rsp_id, g); end
          checks++; if (rsp_result !== (g ? 32'd42 : 32'd7)) begin errors++; $display("FAIL both_result: got %0d want %0d", rsp_result, g ? 42 : 7); end
        end
        nrsp++;
      end
      step(); #1;
    end
    checks++; if (nrsp != 4) begin errors++; $display("FAIL both_timeout: got %0d responses want 4", nrsp); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_div();
    int lat; bit ok;
    do_op(1'b1, mk(5'd6), 32'd100, 32'd0, lat, ok);
    checks++; if (!ok || rsp_result !== 32'd0 || rsp_f !== 4'b0001) begin errors++; $display("FAIL div0: got ok=%0d res=%0d flags=%b want 0/0001", ok, rsp_result, rsp_f); end
    checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL div0_id: got %b want 1", rsp_id); end
    step();
    do_op(1'b1, mk(5'd6), 32'd100, 32'd4, lat, ok);
    checks++; if (!ok || rsp_result !== 32'd25 || rsp_f !== 4'b0000) begin errors++; $display("FAIL div_ok: got ok=%0d res=%0d flags=%b want 25/0000", ok, rsp_result, rsp_f); end
    step();
  endtask

  task automatic test_cmp();
    logic [31:0] ca [3] = '{32'd9, 32'd9, 32'd3};
    logic [31:0] cb [3] = '{32'd9, 32'd3, 32'd9};
    logic [3:0]  cf [3] = '{4'b0100, 4'b0010, 4'b1000};
    int lat; bit ok;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, mk(5'd11), ca[i], cb[i], lat, ok);
      checks++; if (!ok || rsp_f !== cf[i] || rsp_result !== 32'd0) begin errors++; $display("FAIL cmp_%0d: got ok=%0d flags=%b res=%0d want %b/0", i, ok, rsp_f, rsp_result, cf[i]); end
      step();
    end
    do_op(1'b0, mk(5'd3), 32'd9, 32'd3, lat, ok);
    checks++; if (!ok || rsp_f !== 4'b0000 || rsp_result !== 32'd12) begin errors++; $display("FAIL cmp_after_add: got flags=%b res=%0d want 0000/12", rsp_f, rsp_result); end
    step();
  endtask

  task automatic test_backpressure();
    bit ok; bit bad; int lat;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_instr = mk(5'd3); req0_a = 32'd1; req0_b = 32'd2;
    #1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (req0_ready) begin ok = 1'b1; break; end
      step(); #1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_grant0: got no req0_ready want grant"); end
    step();
    req0_valid = 1'b0; rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_instr = mk(5'd4); req1_a = 32'd50; req1_b = 32'd8;
    step();
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!rsp_valid || rsp_result !== 32'd3 || rsp_id !== 1'b0 || rsp_f !== 4'b0000 || req1_ready) bad = 1'b1;
      step();
    end
    checks++; if (bad) begin errors++; $display("FAIL bp_hold: got unstable rsp or req1_ready during stall want stable"); end
    #1;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_same_cycle: got req1_ready=%b want 0", req1_ready); end
    step(); #1;
    checks++; if ({rsp_valid, req1_ready} !== 2'b01) begin errors++; $display("FAIL bp_release: got valid/ready=%b want 01", {rsp_valid, req1_ready}); end
    step();
    req1_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (rsp_valid) begin lat = k; break; end
      step();
    end
    checks++; if (lat != 2 || rsp_id !== 1'b1 || rsp_result !== 32'd42) begin errors++; $display("FAIL bp_req1_rsp: got lat=%0d id=%b res=%0d want 2/1/42", lat, rsp_id, rsp_result); end
    step();
  endtask

  task automatic test_reset_mid();
    bit ok; bit seen; int lat;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_instr = mk(5'd3); req0_a = 32'd4; req0_b = 32'd4;
    #1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (req0_ready) begin ok = 1'b1; break; end
      step(); #1;
    end
    step();
    req0_valid = 1'b0;
    #1;
    checks++; if (!ok || busy !== 1'b1) begin errors++; $display("FAIL rstmid_exec: got ok=%0d busy=%b want busy 1", ok, busy); end
    rst = 1'b1;
    step(); #1;
    checks++; if ({rsp_valid, rsp_id, busy, rsp_result, rsp_f} !== 39'd0) begin errors++; $display("FAIL rstmid_zero: got valid=%b busy=%b res=%h flags=%b want all 0", rsp_valid, busy, rsp_result, rsp_f); end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin step(); #1; if (rsp_valid) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL rstmid_discard: got rsp_valid after reset want none"); end
    do_op(1'b0, mk(5'h1F), 32'd3, 32'd4, lat, ok);
    checks++; if (!ok || rsp_result !== 32'd0 || rsp_error !== 1'b1) begin errors++; $display("FAIL illegal_op: got ok=%0d res=%0d err=%b want 0/1", ok, rsp_result, rsp_error); end
    step();
  endtask

  // Randomized traffic against a transaction model: pending op per requester,
  // round-robin on contention, two cycles to a response, hold until consumed.
  task automatic test_random();
    bit          pend [2];
    logic [31:0] pi [2], pa [2], pb [2];
    int          phase;       // 0 waiting for grant, 1 computing, 2 response out
    bit          lg, g;
    logic [1:0]  exp_rdy;
    logic [31:0] e_res;
    logic [3:0]  e_f;
    bit          e_id;
    rst = 1'b1; step(); rst = 1'b0;
    phase = 0; lg = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1;
          pi[r] = ($urandom_range(0, 9) == 0) ? $urandom : mk(5'(3 + $urandom_range(0, 9)));
          case ($urandom_range(0, 3))
            0:       pb[r] = 32'd0;
            1:       pb[r] = $urandom_range(0, 40);
            default: pb[r] = $urandom;
          endcase
          pa[r] = ($urandom_range(0, 3) == 0) ? pb[r] : $urandom;
        end
      end
      req0_valid = pend[0]; req0_instr = pi[0]; req0_a = pa[0]; req0_b = pb[0];
      req1_valid = pend[1]; req1_instr = pi[1]; req1_a = pa[1]; req1_b = pb[1];
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = 2'b00;
      g = 1'b0;
      if (phase == 0 && (pend[0] || pend[1])) begin
        g = (pend[0] && pend[1]) ? !lg : pend[1];
        exp_rdy = g ? 2'b10 : 2'b01;
      end
      checks++; if ({req1_ready, req0_ready} !== exp_rdy) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, {req1_ready, req0_ready}, exp_rdy); end
      checks++; if (rsp_valid !== (phase == 2) || busy !== (phase != 0)) begin errors++; $display("FAIL rnd_ctrl c%0d: got valid=%b busy=%b want phase %0d", c, rsp_valid, busy, phase); end
      if (phase == 2) begin
        checks++; if (rsp_id !== e_id || rsp_result !== e_res || rsp_f !== e_f) begin errors++; $display("FAIL rnd_rsp c%0d: got id=%b res=%h f=%b want %b/%h/%b", c, rsp_id, rsp_result, rsp_f, e_id, e_res, e_f); end
      end
      case (phase)
        0: if (exp_rdy != 2'b00) begin
             lg = g; e_id = g; pend[g] = 1'b0;
             ref_alu(pi[g], pa[g], pb[g], e_res, e_f);
             phase = 1;
           end
        1: phase = 2;
        default: if (rsp_ready) phase = 0;
      endcase
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    step(); step();
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_instr = 32'd0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_instr = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
    rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_both();
    test_div();
    test_cmp();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
